// File: rtl/poly_pkg.sv
`default_nettype none
// ============================================================================
// Module      : poly_pkg (package)
// Description : Types and constants shared by the polynomial datapath blocks.
//               Provides the sparse sequencer state encoding, the default
//               word width and slot count, and the slot-address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package poly_pkg;

    // Default width of a sparse word and of the controller data word.
    localparam int C_WORD_WIDTH      = 32;
    // Default number of operation slots issued per multiplication.
    localparam int C_MEM_SPARSE_SIZE = 50;
    // Width of the per-operation timeout counter.
    localparam int C_TIMER_W         = 16;
    // Width of the sparse memory address bus.
    localparam int C_ADDR_W          = 10;
    // Width of the weight / slot index fields.
    localparam int C_SLOT_W          = 6;

    // Sparse sequencer FSM states.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_LATCH     = 4'd2,
        S_LAUNCH    = 4'd3,
        S_WAIT_BUSY = 4'd4,
        S_WAIT_DONE = 4'd5,
        S_NEXT      = 4'd6,
        S_FINISH    = 4'd7,
        S_ERROR     = 4'd8
    } seq_state_t;

    // Address fetched for a slot. Real slots read their own position; dummy
    // slots re-read the last real position (or position 0 when there are no
    // real words) so that a dummy slot is indistinguishable in timing.
    function automatic logic [C_ADDR_W-1:0] slot_addr(
        input logic [C_SLOT_W-1:0] slot,
        input logic [C_SLOT_W-1:0] wt
    );
        logic [C_ADDR_W-1:0] addr;
        if (slot < wt) begin
            addr = {{(C_ADDR_W-C_SLOT_W){1'b0}}, slot};
        end else if (wt == '0) begin
            addr = '0;
        end else begin
            addr = {{(C_ADDR_W-C_SLOT_W){1'b0}}, wt - 6'd1};
        end
        return addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/op_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : op_watchdog
// Description : Per-operation timeout counter for the sparse sequencer.
//               The count is cleared when an operation is launched and
//               advances on every cycle spent waiting for the controller.
//               'expired' is raised in the waiting cycle whose increment
//               brings the count to TIMEOUT_CYCLES.
// Ports       : clk     - rising-edge clock
//               rst     - asynchronous active-high reset
//               clear   - zero the count (operation launch)
//               enable  - count this cycle (waiting on the controller)
//               expired - timeout reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module op_watchdog
    import poly_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Count value at the start of the cycle whose increment reaches the limit.
    localparam logic [C_TIMER_W-1:0] C_LAST = C_TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [C_TIMER_W-1:0] r_count;

    assign expired = enable && (r_count == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != {C_TIMER_W{1'b1}})) begin
            // Saturate rather than wrap so a stalled wait can never alias
            // back below the limit.
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sparse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sparse_sequencer
// Description : Constant-time sequencer for sparse polynomial multiplication.
//               Every multiplication issues exactly MEM_SPARSE_SIZE controller
//               operations. Slots beyond the real weight are dummies: they
//               fetch a real position and launch the controller exactly like
//               a real slot, but flag dummy_o so downstream logic redirects
//               the accumulator write to scratch.
// Ports       : clk, rst             - clock, asynchronous active-high reset
//               start, weight        - begin a run with 'weight' real words
//               sparse_mem_addr_o/   - sparse memory read port (data valid
//               sparse_mem_data_i      one cycle after the address)
//               ctrl_sparse_data_o,  - word, launch pulse and busy handshake
//               ctrl_start_o,          with the multiply controller
//               ctrl_busy_i
//               dummy_o, op_count_o  - current slot kind and index
//               busy, done, error    - run status (error is sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module sparse_sequencer
    import poly_pkg::*;
#(
    parameter int WORD_WIDTH      = C_WORD_WIDTH,
    parameter int MEM_SPARSE_SIZE = C_MEM_SPARSE_SIZE,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [C_SLOT_W-1:0]   weight,
    output logic [C_ADDR_W-1:0]   sparse_mem_addr_o,
    input  logic [WORD_WIDTH-1:0] sparse_mem_data_i,
    output logic [WORD_WIDTH-1:0] ctrl_sparse_data_o,
    output logic                  ctrl_start_o,
    input  logic                  ctrl_busy_i,
    output logic                  dummy_o,
    output logic [C_SLOT_W-1:0]   op_count_o,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [C_SLOT_W-1:0] C_SLOTS = C_SLOT_W'(MEM_SPARSE_SIZE);

    seq_state_t          r_state;
    logic [C_SLOT_W-1:0] r_weight;

    logic [C_SLOT_W-1:0] w_sat_weight;
    logic [C_SLOT_W-1:0] w_next_count;
    logic                w_wd_clear;
    logic                w_wd_enable;
    logic                w_timeout;

    // Weights above the slot count cannot be honoured; clamp at capture.
    assign w_sat_weight = (weight > C_SLOTS) ? C_SLOTS : weight;
    assign w_next_count = op_count_o + 6'd1;

    assign w_wd_clear   = (r_state == S_LAUNCH);
    assign w_wd_enable  = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);

    op_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_timeout)
    );

    // The memory address is loaded on the transition into FETCH, so it is
    // already on the bus during FETCH and the read data is valid in LATCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_weight           <= '0;
            sparse_mem_addr_o  <= '0;
            ctrl_sparse_data_o <= '0;
            ctrl_start_o       <= 1'b0;
            dummy_o            <= 1'b0;
            op_count_o         <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
        end else begin
            // Single-cycle pulses fall back low unless re-armed below.
            ctrl_start_o <= 1'b0;
            done         <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_weight          <= w_sat_weight;
                        op_count_o        <= '0;
                        error             <= 1'b0;
                        busy              <= 1'b1;
                        dummy_o           <= 1'b0;
                        sparse_mem_addr_o <= slot_addr('0, w_sat_weight);
                        r_state           <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    r_state <= S_LATCH;
                end

                S_LATCH: begin
                    ctrl_sparse_data_o <= sparse_mem_data_i;
                    dummy_o            <= (op_count_o >= r_weight);
                    // Armed here so the pulse is high for the LAUNCH cycle.
                    ctrl_start_o       <= 1'b1;
                    r_state            <= S_LAUNCH;
                end

                S_LAUNCH: begin
                    r_state <= S_WAIT_BUSY;
                end

                S_WAIT_BUSY: begin
                    if (w_timeout) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_ERROR;
                    end else if (ctrl_busy_i) begin
                        r_state <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    // Entered only after busy was seen high, so the first low
                    // sample here is the falling edge. The controller's own
                    // done flag is sticky and is deliberately not used.
                    if (w_timeout) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_ERROR;
                    end else if (!ctrl_busy_i) begin
                        r_state <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    op_count_o <= w_next_count;
                    if (w_next_count == C_SLOTS) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        dummy_o <= 1'b0;
                        r_state <= S_FINISH;
                    end else begin
                        sparse_mem_addr_o <= slot_addr(w_next_count, r_weight);
                        r_state           <= S_FETCH;
                    end
                end

                // done is high during this cycle; start is not looked at.
                S_FINISH: begin
                    r_state <= S_IDLE;
                end

                S_ERROR: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sparse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sparse_sequencer
// Description : Self-checking bench for sparse_sequencer. A reference model
//               derives the expected slot sequence of each run and queues
//               it; a monitor pops one entry per controller launch. A
//               controller model answers launches with a busy pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sparse_sequencer;
    import poly_pkg::*;

    localparam int WW   = 32;
    localparam int SIZE = 12;
    localparam int TMO  = 20;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [5:0]    weight = '0;
    logic [9:0]    sparse_mem_addr_o;
    logic [WW-1:0] sparse_mem_data_i = '0;
    logic [WW-1:0] ctrl_sparse_data_o;
    logic          ctrl_start_o;
    logic          ctrl_busy_i;
    logic          dummy_o;
    logic [5:0]    op_count_o;
    logic          busy;
    logic          done;
    logic          error;

    sparse_sequencer #(
        .WORD_WIDTH      (WW),
        .MEM_SPARSE_SIZE (SIZE),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .weight             (weight),
        .sparse_mem_addr_o  (sparse_mem_addr_o),
        .sparse_mem_data_i  (sparse_mem_data_i),
        .ctrl_sparse_data_o (ctrl_sparse_data_o),
        .ctrl_start_o       (ctrl_start_o),
        .ctrl_busy_i        (ctrl_busy_i),
        .dummy_o            (dummy_o),
        .op_count_o         (op_count_o),
        .busy               (busy),
        .done               (done),
        .error              (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous sparse memory: data follows the address by one cycle.
    logic [WW-1:0] mem [0:1023];
    always @(posedge clk) sparse_mem_data_i <= mem[sparse_mem_addr_o];

    typedef struct {
        logic [9:0]    addr;
        logic [WW-1:0] data;
        logic          dummy;
        logic [5:0]    idx;
    } slot_t;

    slot_t exp_q[$];
    int    n_total  = 0;
    int    n_pass   = 0;
    int    done_cnt = 0;
    bit    ctrl_mode = 1'b0;  // 1: controller never raises busy
    bit    ctrl_rand = 1'b0;  // 1: random busy delay/length, 0: fixed 2/5

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: the slot list a run with weight w must produce.
    task automatic push_expect(input int w);
        int    we;
        slot_t s;
        we = (w > SIZE) ? SIZE : w;
        for (int i = 0; i < SIZE; i++) begin
            s.idx   = 6'(i);
            s.dummy = (i >= we);
            if (i < we)        s.addr = 10'(i);
            else if (we == 0)  s.addr = 10'd0;
            else               s.addr = 10'(we - 1);
            s.data  = mem[s.addr];
            exp_q.push_back(s);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_addr"},   64'(sparse_mem_addr_o),  0);
        chk({tag, "_data"},   64'(ctrl_sparse_data_o), 0);
        chk({tag, "_cstart"}, 64'(ctrl_start_o),       0);
        chk({tag, "_dummy"},  64'(dummy_o),            0);
        chk({tag, "_count"},  64'(op_count_o),         0);
        chk({tag, "_busy"},   64'(busy),               0);
        chk({tag, "_done"},   64'(done),               0);
        chk({tag, "_error"},  64'(error),              0);
    endtask

    // One complete run. With b2b set the caller is at the negedge of the
    // done cycle: start is raised during FINISH (must be ignored) and held
    // into the following IDLE cycle, where it must be accepted.
    task automatic run_op(input int w, input bit b2b, output int dur);
        int t0;
        bit seen;
        push_expect(w);
        if (b2b) begin
            start = 1'b1; weight = 6'(w);
            @(negedge clk);
            chk("start_in_finish_ignored", 64'(busy), 0);
        end else begin
            @(negedge clk);
            start = 1'b1; weight = 6'(w);
        end
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        chk("busy_after_start", 64'(busy), 1);
        chk("error_cleared_by_start", 64'(error), 0);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_within_budget", 64'(seen), 1);
        dur = cyc - t0;
        if (!seen) exp_q.delete();
    endtask

    // Controller model: after a launch, wait dl cycles then hold busy hl cycles.
    initial begin
        int dl, hl;
        bit st;
        dl = 0; hl = 0; ctrl_busy_i = 1'b0;
        forever begin
            @(negedge clk);
            st = ctrl_start_o;
            @(posedge clk);
            #2;
            if (rst) begin
                ctrl_busy_i = 1'b0; dl = 0; hl = 0;
            end else begin
                if (st && !ctrl_mode && dl == 0 && hl == 0) begin
                    dl = ctrl_rand ? int'($urandom_range(1, 4))  : 2;
                    hl = ctrl_rand ? int'($urandom_range(1, 10)) : 5;
                end
                if (dl > 0) begin
                    dl--;
                    if (dl == 0) ctrl_busy_i = 1'b1;
                end else if (hl > 0) begin
                    hl--;
                    if (hl == 0) ctrl_busy_i = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [9:0] a1, a2;
        logic       pb, pd;
        int         fall_cyc;
        bit         fall_ok;
        slot_t      s;
        a1 = '0; a2 = '0; pb = 1'b0; pd = 1'b0; fall_cyc = 0; fall_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && pb && !ctrl_busy_i) begin
                fall_cyc = cyc; fall_ok = 1'b1;
            end
            if (ctrl_start_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ctrl_start", 1, 0);
                end else begin
                    s = exp_q.pop_front();
                    chk("slot_index", 64'(op_count_o),         64'(s.idx));
                    chk("slot_addr",  64'(a2),                 64'(s.addr));
                    chk("slot_data",  64'(ctrl_sparse_data_o), 64'(s.data));
                    chk("slot_dummy", 64'(dummy_o),            64'(s.dummy));
                    if (fall_ok) chk("slot_overhead", 64'(cyc - fall_cyc), 4);
                end
                fall_ok = 1'b0;
            end
            if (done) begin
                chk("done_all_slots_issued", 64'(exp_q.size()), 0);
                chk("done_single_cycle", 64'(pd), 0);
                chk("busy_low_at_done", 64'(busy), 0);
                done_cnt++;
            end
            if (rst || done || error) fall_ok = 1'b0;
            pb = ctrl_busy_i; pd = done;
            a2 = a1; a1 = sparse_mem_addr_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    // Main stimulus.
    initial begin
        int  d_tmp, c0, c_full, t_start, t_err, base;
        bit  seen;
        logic [31:0] r;
        for (int i = 0; i < 1024; i++) begin
            r = $urandom();
            mem[i] = {r[21:0], 10'(i)};
        end

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Directed runs with fixed controller timing.
        ctrl_rand = 1'b0;
        run_op(3, 1'b0, d_tmp);
        run_op(0, 1'b0, c0);
        run_op(SIZE, 1'b0, c_full);
        chk("weight0_same_duration", 64'(c0), 64'(c_full));
        run_op(63, 1'b1, d_tmp);

        // Randomised runs, alternating back-to-back starts.
        ctrl_rand = 1'b1;
        for (int k = 0; k < 6; k++) run_op(int'($urandom_range(0, 63)), k[0], d_tmp);

        // Timeout: controller never answers.
        ctrl_mode = 1'b1;
        push_expect(5);
        @(negedge clk); start = 1'b1; weight = 6'd5;
        @(negedge clk); start = 1'b0;
        seen = 1'b0; t_start = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (ctrl_start_o) begin t_start = cyc; seen = 1'b1; end
        end
        chk("timeout_launch_seen", 64'(seen), 1);
        base = done_cnt;
        seen = 1'b0; t_err = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (error) begin t_err = cyc; seen = 1'b1; end
        end
        exp_q.delete();
        chk("timeout_error_set", 64'(seen), 1);
        chk("timeout_latency", 64'(t_err - t_start), 64'(TMO + 1));
        chk("timeout_busy_cleared", 64'(busy), 0);
        repeat (3) @(negedge clk);
        chk("timeout_no_done", 64'(done_cnt), 64'(base));
        chk("error_sticky", 64'(error), 1);
        ctrl_mode = 1'b0;
        run_op(5, 1'b0, d_tmp);

        // Reset during WAIT_DONE of slot 2.
        ctrl_rand = 1'b0;
        push_expect(6);
        @(negedge clk); start = 1'b1; weight = 6'd6;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (op_count_o == 6'd2 && ctrl_busy_i && busy) seen = 1'b1;
        end
        chk("reached_slot2_wait_done", 64'(seen), 1);
        @(negedge clk);
        base = done_cnt;
        rst = 1'b1;
        #1;
        chk_idle_outputs("abort_now");
        @(negedge clk);
        chk_idle_outputs("abort_next");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_no_done", 64'(done_cnt), 64'(base));
        run_op(4, 1'b0, d_tmp);
        run_op(2, 1'b1, d_tmp);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sparse_sequencer.md
SPARSE_SEQUENCER -- requirements
Module: sparse_sequencer

Interface
REQ-001 Parameter WORD_WIDTH, default 32, width of the sparse word and the controller data word.
REQ-002 Parameter MEM_SPARSE_SIZE, default 50, number of operation slots per multiplication (fixed count, constant time).
REQ-003 Parameter TIMEOUT_CYCLES, default 65535, maximum cycles allowed per controller operation.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst  in  1  asynchronous, active-high reset.
REQ-007 Port: start  in  1  one-cycle pulse that begins a multiplication.
REQ-008 Port: weight  in  6  number of real sparse words (0..MEM_SPARSE_SIZE), sampled on start.
REQ-009 Port: sparse_mem_addr_o  out  10  sparse memory read address.
REQ-010 Port: sparse_mem_data_i  in  WORD_WIDTH  sparse word, valid one cycle after the address.
REQ-011 Port: ctrl_sparse_data_o  out  WORD_WIDTH  word presented to the controller ([31:16] high position, [15:0] low position).
REQ-012 Port: ctrl_start_o  out  1  start pulse to the controller.
REQ-013 Port: ctrl_busy_i  in  1  controller busy.
REQ-014 Port: dummy_o  out  1  current slot is a dummy; downstream redirects the accumulator write to scratch.
REQ-015 Port: op_count_o  out  6  index of the current slot.
REQ-016 Port: busy  out  1  multiplication in progress.
REQ-017 Port: done  out  1  one-cycle pulse when all slots have completed.
REQ-018 Port: error  out  1  sticky timeout flag, cleared by the next start or by reset.

Function
REQ-019 FSM states: IDLE, FETCH, LATCH, LAUNCH, WAIT_BUSY, WAIT_DONE, NEXT, FINISH, ERROR.
REQ-020 IDLE: on start, latch weight, clear op_count_o and error, set busy, and go to FETCH; start is ignored in every other state.
REQ-021 FETCH: drive sparse_mem_addr_o = op_count_o when op_count_o < weight, else drive the last real address (weight-1, or 0 if weight = 0); then go to LATCH.
REQ-022 LATCH: capture sparse_mem_data_i into ctrl_sparse_data_o, set dummy_o = (op_count_o >= weight), and go to LAUNCH.
REQ-023 Dummy slots SHALL reuse the fetched positions so that timing is identical to a real slot; dummy_o is the only difference.
REQ-024 LAUNCH: assert ctrl_start_o for exactly one cycle, then go to WAIT_BUSY.
REQ-025 WAIT_BUSY: wait for ctrl_busy_i = 1, then go to WAIT_DONE.
REQ-026 WAIT_DONE: completion is the falling edge of ctrl_busy_i (1 to 0); the controller's done is sticky, so the block SHALL NOT sample it.
REQ-027 On completion, go to NEXT.
REQ-028 NEXT: increment op_count_o; if it equals MEM_SPARSE_SIZE, go to FINISH, else go to FETCH.
REQ-029 Per-slot overhead, from completion to the next ctrl_start_o, SHALL be exactly 4 cycles (NEXT, FETCH, LATCH, LAUNCH).
REQ-030 FINISH: pulse done for one cycle, clear busy and dummy_o, and return to IDLE.
REQ-031 Timeout counter (16 bits): cleared in LAUNCH and incremented in WAIT_BUSY and WAIT_DONE.
REQ-032 When the timeout counter reaches TIMEOUT_CYCLES, go to ERROR, set error, and clear busy.
REQ-033 ERROR: return to IDLE on the next cycle; done SHALL NOT pulse.
REQ-034 weight = 0: all MEM_SPARSE_SIZE slots are dummy and use address 0.
REQ-035 weight > MEM_SPARSE_SIZE: the latched weight SHALL be saturated to MEM_SPARSE_SIZE.
REQ-036 A start arriving in the same cycle as FINISH SHALL be ignored.

Reset
REQ-037 While rst is high: state = IDLE; all outputs are 0, including sparse_mem_addr_o, ctrl_sparse_data_o, op_count_o and error; the latched weight and the timeout counter are 0.
REQ-038 Reset asserted mid-operation SHALL abort immediately, with no done and no further ctrl_start_o.

Structure
REQ-039 The FSM state encoding and the WORD_WIDTH/MEM_SPARSE_SIZE defaults SHALL live in the shared package poly_pkg.
REQ-040 The block is a single module; the timeout counter MAY be the sub-module op_watchdog.

Verification
REQ-041 weight = 3, MEM_SPARSE_SIZE = 4, controller model busy for 10 cycles -> 4 ctrl_start_o pulses; dummy_o = 0,0,0,1; the slot-3 address is 2; exactly one done pulse.
REQ-042 weight = 0 -> 50 ctrl_start_o pulses, all with dummy_o = 1 and address 0; total cycle count equals that of a weight = 50 run.
REQ-043 Controller model never raises busy, TIMEOUT_CYCLES = 20 -> error = 1 after 20 cycles in WAIT_BUSY, no done, busy = 0.
REQ-044 Reset asserted in WAIT_DONE of slot 2 -> all outputs are 0 in the next cycle; a subsequent start restarts from slot 0.
REQ-045 Back-to-back runs (start in the cycle after done) -> both runs complete; error cleared; op_count_o restarts at 0.
